// File: rtl/conv_window_gen_if.sv
// Pixel-stream in / window-stream out bundle for the sliding-window generator.
// Latency: none (wires only).
// Backpressure: none; the source pushes pixels with pix_valid, the sink samples windows on en_out.
interface conv_window_gen_if #(
  parameter int KERNEL = 3,
  parameter int N      = 4
);
  logic [N-1:0]               pix_in;
  logic                       pix_valid;
  logic                       frame_start;
  logic [KERNEL*KERNEL*N-1:0] data2conv;
  logic                       en_out;
  logic                       frame_done;

  // Pixel source / window consumer side
  modport master (
    output pix_in, pix_valid, frame_start,
    input  data2conv, en_out, frame_done
  );

  // Window generator side
  modport slave (
    input  pix_in, pix_valid, frame_start,
    output data2conv, en_out, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding KERNELxKERNEL window generator over a raster pixel stream ("valid" convolution, no padding).
// Latency: window and en_out registered, one cycle after the accepting edge; one window per cycle.
// Backpressure: none; gaps in pix_valid stall all state and suppress strobes.
module conv_window_gen #(
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst,
  conv_window_gen_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WW = KERNEL * KERNEL * N;

  logic [CW-1:0] col, cur_col, col_nxt;
  logic [RW-1:0] row, cur_row, row_nxt;
  logic          win_ok, last_pix;

  logic [N-1:0]  col_vec [KERNEL];
  logic [N-1:0]  win     [KERNEL][KERNEL];
  logic [N-1:0]  win_nxt [KERNEL][KERNEL];
  logic [WW-1:0] win_flat;

  logic [WW-1:0] data_q;
  logic          en_q, done_q;

  assign bus.data2conv  = data_q;
  assign bus.en_out     = en_q;
  assign bus.frame_done = done_q;

  // Position of the current pixel; frame_start forces it to (0,0)
  always_comb begin
    cur_col  = bus.frame_start ? '0 : col;
    cur_row  = bus.frame_start ? '0 : row;
    win_ok   = (int'(cur_row) >= KERNEL - 1) && (int'(cur_col) >= KERNEL - 1);
    last_pix = (int'(cur_row) == IMG_H - 1) && (int'(cur_col) == IMG_W - 1);
    col_nxt  = cur_col + 1'b1;
    row_nxt  = cur_row;
    if (int'(cur_col) == IMG_W - 1) begin
      col_nxt = '0;
      row_nxt = (int'(cur_row) == IMG_H - 1) ? '0 : cur_row + 1'b1;
    end
  end

  generate
    if (KERNEL > 1) begin : g_lb
      // lb[0] is the previous line, lb[KERNEL-2] the oldest; contents are never reset
      logic [N-1:0] lb [KERNEL-1][IMG_W];

      // Column vector: oldest line on top, incoming pixel at the bottom
      always_comb begin
        col_vec[KERNEL-1] = bus.pix_in;
        for (int r = 0; r < KERNEL - 1; r++) begin
          col_vec[r] = lb[KERNEL-2-r][cur_col];
        end
      end

      // Push the incoming pixel down the line-memory column at the current position
      always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
          lb[0][cur_col] <= bus.pix_in;
          for (int b = 1; b < KERNEL - 1; b++) begin
            lb[b][cur_col] <= lb[b-1][cur_col];
          end
        end
      end
    end else begin : g_nolb
      // Single-pixel window: the column is just the incoming pixel
      always_comb begin
        col_vec[0] = bus.pix_in;
      end
    end
  endgenerate

  // Next window: shift left one column, new column enters on the right; also pack for output
  always_comb begin
    win_flat = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL - 1; c++) begin
        win_nxt[r][c] = win[r][c+1];
      end
      win_nxt[r][KERNEL-1] = col_vec[r];
    end
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        win_flat[(r*KERNEL+c)*N +: N] = win_nxt[r][c];
      end
    end
  end

  // Raster position counters, advanced once per accepted pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.pix_valid) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Window register array, shifted on every accepted pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (bus.pix_valid) begin
      win <= win_nxt;
    end
  end

  // Output stage: data only updates on a real window so it holds between strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      en_q   <= bus.pix_valid && win_ok;
      done_q <= bus.pix_valid && win_ok && last_pix;
      if (bus.pix_valid && win_ok) begin
        data_q <= win_flat;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench: KERNEL=3 and KERNEL=1 generators on a 4x4 image fed the same stream.
// A frame-image reference model pushes expected windows; a negedge monitor pops and compares.
// Directed frames from the test plan plus a randomized stream with gaps and restarts.
module tb_conv_window_gen;

  typedef struct packed {
    logic [35:0] d;
    logic        fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pix = '0;
  logic       pv  = 1'b0;
  logic       fst = 1'b0;

  exp_t        sb3[$];
  exp_t        sb1[$];
  logic [35:0] obs3[$];
  int          cnt1 = 0;
  bit          drv3 = 1'b0, drv1 = 1'b0;
  bit          e3 = 1'b0, e1 = 1'b0;
  int          n_chk = 0, n_fail = 0;
  logic [3:0]  img [4][4];
  int          pos = 0;

  always #5 clk = ~clk;

  conv_window_gen_if #(.KERNEL(3), .N(4)) b3 ();
  conv_window_gen_if #(.KERNEL(1), .N(4)) b1 ();

  assign b3.pix_in = pix;  assign b3.pix_valid = pv;  assign b3.frame_start = fst;
  assign b1.pix_in = pix;  assign b1.pix_valid = pv;  assign b1.frame_start = fst;

  conv_window_gen #(.KERNEL(3), .N(4), .IMG_W(4), .IMG_H(4)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
  conv_window_gen #(.KERNEL(1), .N(4), .IMG_W(4), .IMG_H(4)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Base-frame window whose top-left pixel has value 'base' (pixel value = row*4+col)
  function automatic logic [35:0] mk(input int base);
    logic [35:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*4 +: 4] = 4'(base + r*4 + c);
    return w;
  endfunction

  // Drive one cycle; reference model places accepted pixels in a frame image
  task automatic send(input logic [3:0] p, input bit v, input bit fs);
    int r, c;
    logic [35:0] w;
    pix = p; pv = v; fst = fs;
    drv3 = 1'b0; drv1 = 1'b0;
    if (v) begin
      if (fs) pos = 0;
      r = pos / 4;
      c = pos % 4;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        w = '0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            w[(rr*3+cc)*4 +: 4] = img[r-2+rr][c-2+cc];
        sb3.push_back('{d: w, fd: (pos == 15)});
        drv3 = 1'b1;
      end
      sb1.push_back('{d: {32'b0, p}, fd: (pos == 15)});
      drv1 = 1'b1;
      pos = (pos + 1) % 16;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(4'd0, 1'b0, 1'b0);
  endtask

  // Expected strobe for the current cycle: whatever the pixel accepted at the last edge produced
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e3 <= 1'b0;
      e1 <= 1'b0;
    end else begin
      e3 <= drv3;
      e1 <= drv1;
    end
  end

  // Monitor: compare strobes every cycle, pop and compare window contents on en_out
  always @(negedge clk) begin
    exp_t e;
    chk("k3_en_out", 36'(b3.en_out), 36'(e3));
    if (b3.en_out) begin
      obs3.push_back(b3.data2conv);
      if (sb3.size() == 0) begin
        chk("k3_unexpected_window", 36'(b3.en_out), 36'(0));
      end else begin
        e = sb3.pop_front();
        chk("k3_data2conv", b3.data2conv, e.d);
        chk("k3_frame_done", 36'(b3.frame_done), 36'(e.fd));
      end
    end else begin
      chk("k3_frame_done_idle", 36'(b3.frame_done), 36'(0));
    end
    chk("k1_en_out", 36'(b1.en_out), 36'(e1));
    if (b1.en_out) begin
      cnt1++;
      if (sb1.size() == 0) begin
        chk("k1_unexpected_window", 36'(b1.en_out), 36'(0));
      end else begin
        e = sb1.pop_front();
        chk("k1_data2conv", 36'(b1.data2conv), e.d);
        chk("k1_frame_done", 36'(b1.frame_done), 36'(e.fd));
      end
    end else begin
      chk("k1_frame_done_idle", 36'(b1.frame_done), 36'(0));
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_k3_data2conv", b3.data2conv, 36'(0));
    chk("rst_k3_en_out", 36'(b3.en_out), 36'(0));
    chk("rst_k3_frame_done", 36'(b3.frame_done), 36'(0));
    chk("rst_k1_data2conv", 36'(b1.data2conv), 36'(0));
    rst = 1'b1;
    idle(2);

    // Base frame
    obs3.delete(); cnt1 = 0;
    for (int i = 0; i < 16; i++) send(4'(i), 1'b1, i == 0);
    idle(3);
    chk("base_count", 36'(obs3.size()), 36'(4));
    chk("base_first", obs3[0], mk(0));
    chk("base_last", obs3[3], mk(5));
    chk("k1_count", 36'(cnt1), 36'(16));

    // Gapped stream
    obs3.delete();
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b1, i == 0);
      send(4'hf, 1'b0, 1'b1);
    end
    idle(3);
    chk("gap_count", 36'(obs3.size()), 36'(4));
    chk("gap_second", obs3[1], mk(1));
    chk("gap_third", obs3[2], mk(4));

    // Back-to-back frames, second shifted by +1, no frame_start
    obs3.delete();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) send(4'((i + f) % 16), 1'b1, 1'b0);
    idle(3);
    chk("b2b_count", 36'(obs3.size()), 36'(8));
    chk("b2b_fifth", obs3[4], mk(1));

    // Mid-frame restart after one window of a partial frame
    obs3.delete();
    for (int i = 0; i < 11; i++) send(4'(i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send(4'(i), 1'b1, i == 0);
    idle(3);
    chk("restart_count", 36'(obs3.size()), 36'(5));
    chk("restart_first", obs3[1], mk(0));
    chk("restart_last", obs3[4], mk(5));

    // Randomized stream with gaps and occasional restarts
    for (int n = 0; n < 400; n++)
      send(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    idle(3);

    // Reset while a window strobe is showing
    for (int i = 0; i < 11; i++) send(4'(i), 1'b1, i == 0);
    #1;
    rst = 1'b0; pv = 1'b0; fst = 1'b0;
    drv3 = 1'b0; drv1 = 1'b0;
    sb3.delete(); sb1.delete();
    pos = 0;
    #1;
    chk("midrst_en_out", 36'(b3.en_out), 36'(0));
    chk("midrst_frame_done", 36'(b3.frame_done), 36'(0));
    chk("midrst_data2conv", b3.data2conv, 36'(0));
    chk("midrst_k1_data2conv", 36'(b1.data2conv), 36'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    obs3.delete();
    for (int i = 0; i < 16; i++) send(4'(i), 1'b1, 1'b0);
    idle(3);
    chk("postrst_count", 36'(obs3.size()), 36'(4));
    chk("postrst_first", obs3[0], mk(0));
    chk("postrst_last", obs3[3], mk(5));

    chk("k3_scoreboard_drained", 36'(sb3.size()), 36'(0));
    chk("k1_scoreboard_drained", 36'(sb1.size()), 36'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
